// File: rtl/seq_multiplier.sv
// seq_multiplier -- iterative shift-add unsigned multiplier with register-file
// writeback. One operation at a time: accept operands in IDLE, run the
// shift-add loop in RUN, present the result for one cycle in WB.
//
// Ports
//   clock      in   sole clock, rising edge
//   reset      in   synchronous, active-high; aborts any operation
//   start      in   request a multiply (sampled only in IDLE)
//   high       in   0: return low W bits (MUL), 1: high W bits (MULHU)
//   A, B       in   W-bit unsigned operands
//   Rd         in   destination register index
//   busy       out  high in RUN and WB
//   RegWrite   out  register-file write enable (WB only, never for Rd=0)
//   WriteReg   out  register-file write index (WB only, else 0)
//   WriteData  out  register-file write data (WB only, else 0)
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start; operands latched on the accepting edge
// RUN    | W shift-add steps, then one edge that moves on to WB
// WB     | result presented on the write port for exactly one cycle
module seq_multiplier #(
  parameter int W = 32
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           start,
  input  logic           high,
  input  logic [W-1:0]   A,
  input  logic [W-1:0]   B,
  input  logic [4:0]     Rd,
  output logic           busy,
  output logic           RegWrite,
  output logic [4:0]     WriteReg,
  output logic [W-1:0]   WriteData
);

  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] CNT_DONE = CW'(W);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_WB   = 2'd2;

  logic [1:0]     state_q, state_d;
  logic [2*W-1:0] prod_q,  prod_d;
  logic [W-1:0]   mcand_q, mcand_d;
  logic [CW-1:0]  cnt_q,   cnt_d;
  logic [4:0]     rd_q,    rd_d;
  logic           high_q,  high_d;

  // Upper half plus conditional multiplicand, kept one bit wider so the
  // carry shifts back into the top of the product instead of being lost.
  logic [W:0] sum;

  always_comb begin
    sum = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, mcand_q} : {(W+1){1'b0}});
  end

  always_comb begin
    state_d = state_q;
    prod_d  = prod_q;
    mcand_d = mcand_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    high_d  = high_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mcand_d = A;
          prod_d  = {{W{1'b0}}, B};
          cnt_d   = '0;
          rd_d    = Rd;
          high_d  = high;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // The counter reaches W after the last step; the edge that sees it
        // there only changes state, which gives the W+1 edge RUN dwell.
        if (cnt_q == CNT_DONE) begin
          state_d = S_WB;
        end else begin
          prod_d = {sum, prod_q[W-1:1]};
          cnt_d  = cnt_q + CNT_ONE;
        end
      end
      S_WB: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      prod_q  <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
      rd_q    <= '0;
      high_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prod_q  <= prod_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      high_q  <= high_d;
    end
  end

  logic in_wb;

  always_comb begin
    in_wb     = (state_q == S_WB);
    busy      = (state_q != S_IDLE);
    RegWrite  = in_wb && (rd_q != 5'd0);
    WriteReg  = in_wb ? rd_q : 5'd0;
    WriteData = '0;
    if (in_wb) begin
      WriteData = high_q ? prod_q[2*W-1:W] : prod_q[W-1:0];
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
module tb_seq_multiplier;

  localparam int W = 32;

  logic          clock;
  logic          reset;
  logic          start;
  logic          high;
  logic [W-1:0]  A;
  logic [W-1:0]  B;
  logic [4:0]    Rd;
  logic          busy;
  logic          RegWrite;
  logic [4:0]    WriteReg;
  logic [W-1:0]  WriteData;

  int checks = 0;
  int errors = 0;

  seq_multiplier #(.W(W)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .high      (high),
    .A         (A),
    .B         (B),
    .Rd        (Rd),
    .busy      (busy),
    .RegWrite  (RegWrite),
    .WriteReg  (WriteReg),
    .WriteData (WriteData)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one multiply and checks every cycle from the accepting edge N
  // through the edge N+W+2 that returns to IDLE. Operands are scrambled
  // right after acceptance; with disturb set, extra start pulses are
  // driven during RUN and during WB and must be ignored.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [4:0] rd, input logic hi,
                       input bit disturb, input string tag);
    logic [2*W-1:0] p;
    logic [W-1:0]   exp_data;
    p        = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    exp_data = hi ? p[2*W-1:W] : p[W-1:0];
    A = a; B = b; Rd = rd; high = hi; start = 1'b1;
    tick();
    start = 1'b0;
    A = $urandom; B = $urandom; Rd = 5'($urandom); high = 1'($urandom);
    for (int k = 0; k <= W + 1; k++) begin
      check({tag, ".busy"}, 64'(busy), 64'd1);
      if (k == W + 1) begin
        check({tag, ".regwrite_wb"}, 64'(RegWrite), 64'(rd != 5'd0));
        check({tag, ".writereg"}, 64'(WriteReg), 64'(rd));
        check({tag, ".writedata"}, 64'(WriteData), 64'(exp_data));
      end else begin
        check({tag, ".regwrite_run"}, 64'(RegWrite), 64'd0);
        check({tag, ".data_run"}, 64'(WriteData), 64'd0);
      end
      start = 1'b0;
      if (disturb && (k == 4 || k == W + 1)) begin
        start = 1'b1;
        A = 100;
      end
      tick();
    end
    start = 1'b0;
    check({tag, ".idle_busy"}, 64'(busy), 64'd0);
    check({tag, ".idle_regwrite"}, 64'(RegWrite), 64'd0);
    check({tag, ".idle_data"}, 64'(WriteData), 64'd0);
    check({tag, ".idle_reg"}, 64'(WriteReg), 64'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; high = 1'b0; A = '0; B = '0; Rd = '0;
    tick();
    tick();
    check("reset.busy", 64'(busy), 64'd0);
    check("reset.regwrite", 64'(RegWrite), 64'd0);
    check("reset.writereg", 64'(WriteReg), 64'd0);
    check("reset.writedata", 64'(WriteData), 64'd0);
    reset = 1'b0;
    tick();
    check("idle.busy", 64'(busy), 64'd0);

    do_op(32'd3, 32'd5, 5'd7, 1'b0, 1'b0, "mul_3x5");
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9, 1'b1, 1'b0, "mulhu_max");
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9, 1'b0, 1'b0, "mul_max");
    do_op(32'h8000_0000, 32'd2, 5'd0, 1'b1, 1'b0, "rd0");
    do_op(32'd6, 32'd7, 5'd3, 1'b0, 1'b1, "ignore_start");
    do_op(32'd0, 32'h1234_5678, 5'd31, 1'b0, 1'b0, "zero_a");

    for (int i = 0; i < 10; i++) begin
      do_op(32'($urandom), 32'($urandom), 5'($urandom_range(0, 31)),
            1'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), "rand");
    end

    // Abort mid-run, with start also held high on the reset edge.
    A = 32'd10; B = 32'd10; Rd = 5'd5; high = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i < 10; i++) tick();
    reset = 1'b1;
    start = 1'b1;
    tick();
    check("abort.busy", 64'(busy), 64'd0);
    check("abort.regwrite", 64'(RegWrite), 64'd0);
    check("abort.writereg", 64'(WriteReg), 64'd0);
    check("abort.writedata", 64'(WriteData), 64'd0);
    reset = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      check("abort.no_busy", 64'(busy), 64'd0);
      check("abort.no_write", 64'(RegWrite), 64'd0);
    end
    do_op(32'd2, 32'd4, 5'd1, 1'b0, 1'b0, "after_abort");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
